// File: rtl/spi_tx_arbiter.sv
// Round-robin arbiter and word sequencer in front of the 16-bit SPI slave
// transmitter. Grants one requester at a time and tracks SCLK falling edges
// to know when the word has left MISO. Aborts on a stalled master.
module spi_tx_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned WORD_W         = 16,
  parameter int unsigned EDGES_PER_WORD = 17,
  parameter int unsigned GUARD_CYCLES   = 2,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*WORD_W-1:0]     req_data,
  output logic [NUM_REQ-1:0]            req_ack,
  output logic [NUM_REQ-1:0]            req_done,
  input  logic                          sclk,
  output logic                          tx_start,
  output logic [WORD_W-1:0]             tx_data,
  output logic                          tx_reset,
  output logic                          busy,
  output logic [$clog2(NUM_REQ)-1:0]    owner,
  output logic                          timeout_err
);

  localparam int unsigned OWN_W        = $clog2(NUM_REQ);
  localparam int unsigned EDGE_W       = $clog2(EDGES_PER_WORD + 1);
  localparam int unsigned TO_W         = $clog2(TIMEOUT_CYCLES);
  localparam int unsigned ABORT_CYCLES = 2;
  localparam int unsigned PH_MAX       = (GUARD_CYCLES > ABORT_CYCLES) ? GUARD_CYCLES : ABORT_CYCLES;
  localparam int unsigned PH_W         = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_SHIFT = 3'd2,
    S_GUARD = 3'd3,
    S_ABORT = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [OWN_W-1:0]    ptr_q, ptr_d;
  logic [OWN_W-1:0]    owner_q, owner_d;
  logic [WORD_W-1:0]   tx_data_q, tx_data_d;
  logic [EDGE_W-1:0]   edge_cnt_q, edge_cnt_d;
  logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
  logic [PH_W-1:0]     ph_cnt_q, ph_cnt_d;
  logic                sync1_q, sync1_d;
  logic                sync2_q, sync2_d;
  logic                sclk_prev_q, sclk_prev_d;
  logic [NUM_REQ-1:0]  req_ack_q, req_ack_d;
  logic [NUM_REQ-1:0]  req_done_q, req_done_d;
  logic                tx_start_q, tx_start_d;
  logic                busy_q, busy_d;
  logic                timeout_err_q, timeout_err_d;
  logic                tx_reset_q, tx_reset_d;

  logic                fall;
  logic                grant_vld;
  logic [OWN_W-1:0]    grant_idx;
  logic [WORD_W-1:0]   grant_word;
  logic [OWN_W:0]      cand;
  logic [OWN_W-1:0]    ptr_next;

  // SCLK synchronizer and falling-edge detector; idle level of SCLK is high
  always_comb begin
    sync1_d     = sclk;
    sync2_d     = sync1_q;
    sclk_prev_d = sync2_q;
    fall        = sclk_prev_q & ~sync2_q;
  end

  // Round-robin pick: first set req bit scanning upward from ptr with wrap
  always_comb begin
    grant_vld  = 1'b0;
    grant_idx  = '0;
    grant_word = '0;
    cand       = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, ptr_q} + (OWN_W+1)'(i);
      if (cand >= (OWN_W+1)'(NUM_REQ)) begin
        cand = cand - (OWN_W+1)'(NUM_REQ);
      end
      if (!grant_vld && req[cand[OWN_W-1:0]]) begin
        grant_vld = 1'b1;
        grant_idx = cand[OWN_W-1:0];
      end
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == OWN_W'(i)) begin
        grant_word = req_data[i*WORD_W +: WORD_W];
      end
    end
  end

  // Pointer advances past the owner so the same requester is not favoured
  always_comb begin
    if (owner_q == OWN_W'(NUM_REQ - 1)) begin
      ptr_next = '0;
    end else begin
      ptr_next = owner_q + OWN_W'(1);
    end
  end

  // Next-state and registered-output logic of the sequencer
  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    owner_d       = owner_q;
    tx_data_d     = tx_data_q;
    edge_cnt_d    = edge_cnt_q;
    to_cnt_d      = to_cnt_q;
    ph_cnt_d      = ph_cnt_q;
    req_ack_d     = '0;
    req_done_d    = '0;
    tx_start_d    = 1'b0;
    timeout_err_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // Edges seen while idle never count toward a word
        edge_cnt_d = '0;
        to_cnt_d   = '0;
        if (grant_vld) begin
          owner_d              = grant_idx;
          tx_data_d            = grant_word;
          req_ack_d[grant_idx] = 1'b1;
          tx_start_d           = 1'b1;
          state_d              = S_LOAD;
        end
      end

      S_LOAD: begin
        ptr_d      = ptr_next;
        edge_cnt_d = '0;
        to_cnt_d   = '0;
        state_d    = S_SHIFT;
      end

      S_SHIFT: begin
        if (fall) begin
          edge_cnt_d = edge_cnt_q + EDGE_W'(1);
          to_cnt_d   = '0;
          if (edge_cnt_q == EDGE_W'(EDGES_PER_WORD - 1)) begin
            ph_cnt_d = '0;
            state_d  = S_GUARD;
          end
        end else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
          ph_cnt_d      = '0;
          timeout_err_d = 1'b1;
          state_d       = S_ABORT;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end

      S_GUARD: begin
        // Lets the transmitter get back to its wait state before the next word
        if (ph_cnt_q == PH_W'(GUARD_CYCLES - 1)) begin
          ph_cnt_d            = '0;
          req_done_d[owner_q] = 1'b1;
          state_d             = S_IDLE;
        end else begin
          ph_cnt_d = ph_cnt_q + PH_W'(1);
        end
      end

      S_ABORT: begin
        if (ph_cnt_q == PH_W'(ABORT_CYCLES - 1)) begin
          ph_cnt_d = '0;
          state_d  = S_IDLE;
        end else begin
          ph_cnt_d = ph_cnt_q + PH_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d     = (state_d != S_IDLE);
    tx_reset_d = (state_d == S_ABORT);
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      ptr_q         <= '0;
      owner_q       <= '0;
      tx_data_q     <= '0;
      edge_cnt_q    <= '0;
      to_cnt_q      <= '0;
      ph_cnt_q      <= '0;
      sync1_q       <= 1'b1;
      sync2_q       <= 1'b1;
      sclk_prev_q   <= 1'b1;
      req_ack_q     <= '0;
      req_done_q    <= '0;
      tx_start_q    <= 1'b0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
      tx_reset_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      owner_q       <= owner_d;
      tx_data_q     <= tx_data_d;
      edge_cnt_q    <= edge_cnt_d;
      to_cnt_q      <= to_cnt_d;
      ph_cnt_q      <= ph_cnt_d;
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      sclk_prev_q   <= sclk_prev_d;
      req_ack_q     <= req_ack_d;
      req_done_q    <= req_done_d;
      tx_start_q    <= tx_start_d;
      busy_q        <= busy_d;
      timeout_err_q <= timeout_err_d;
      tx_reset_q    <= tx_reset_d;
    end
  end

  // Transmitter is held in reset whenever this block is
  assign tx_reset    = tx_reset_q | ~reset_n;
  assign req_ack     = req_ack_q;
  assign req_done    = req_done_q;
  assign tx_start    = tx_start_q;
  assign tx_data     = tx_data_q;
  assign busy        = busy_q;
  assign owner       = owner_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_spi_tx_arbiter.sv
// Scoreboard bench for spi_tx_arbiter: stimulus pushes expected grant/done/
// timeout events with their cycle of arrival; a monitor pops and compares.
module tb_spi_tx_arbiter;

  localparam int NREQ  = 4;
  localparam int WW    = 16;
  localparam int EDGES = 17;
  localparam int TOC   = 4096;

  localparam int K_GRANT = 0;
  localparam int K_DONE  = 1;
  localparam int K_TO    = 2;

  typedef struct {
    int          kind;
    int          idx;
    logic [15:0] data;
    int          at;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [NREQ-1:0]   req;
  logic [NREQ*WW-1:0] req_data;
  logic [NREQ-1:0]   req_ack;
  logic [NREQ-1:0]   req_done;
  logic              sclk;
  logic              tx_start;
  logic [WW-1:0]     tx_data;
  logic              tx_reset;
  logic              busy;
  logic [1:0]        owner;
  logic              timeout_err;

  exp_t        exp_q[$];
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  int          abort_phase = 0;
  logic [15:0] wd [4];

  spi_tx_arbiter #(
    .NUM_REQ(NREQ), .WORD_W(WW), .EDGES_PER_WORD(EDGES),
    .GUARD_CYCLES(2), .TIMEOUT_CYCLES(TOC)
  ) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .req_data(req_data),
    .req_ack(req_ack), .req_done(req_done), .sclk(sclk),
    .tx_start(tx_start), .tx_data(tx_data), .tx_reset(tx_reset),
    .busy(busy), .owner(owner), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void push(input int kind, input int idx, input int at);
    exp_t e;
    e.kind = kind;
    e.idx  = idx;
    e.data = wd[idx];
    e.at   = at;
    exp_q.push_back(e);
  endfunction

  task automatic match(input int kind);
    exp_t       e;
    logic [3:0] oh;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected event: got kind %0d expected none (cycle %0d)", kind, cyc);
    end else begin
      e = exp_q.pop_front();
      oh = '0;
      oh[e.idx[1:0]] = 1'b1;
      chk("event kind", 32'(kind), 32'(e.kind));
      chk("event cycle", 32'(cyc), 32'(e.at));
      chk("owner", 32'(owner), 32'(e.idx));
      if (kind == K_GRANT) begin
        chk("grant req_ack", 32'(req_ack), 32'(oh));
        chk("grant tx_start", 32'(tx_start), 32'(1));
        chk("grant tx_data", 32'(tx_data), 32'(e.data));
        chk("grant busy", 32'(busy), 32'(1));
      end else if (kind == K_DONE) begin
        chk("done req_done", 32'(req_done), 32'(oh));
        chk("done busy", 32'(busy), 32'(0));
      end else begin
        chk("abort tx_reset", 32'(tx_reset), 32'(1));
        chk("abort no done", 32'(req_done), 32'(0));
      end
    end
  endtask

  // Monitor: sample mid-cycle and consume expectations as events appear
  initial begin
    forever begin
      @(negedge clk);
      if (reset_n === 1'b1) begin
        if (abort_phase == 1) begin
          chk("abort 2nd tx_reset", 32'(tx_reset), 32'(1));
          chk("abort 2nd timeout_err", 32'(timeout_err), 32'(0));
          abort_phase = 2;
        end else if (abort_phase == 2) begin
          chk("abort end tx_reset", 32'(tx_reset), 32'(0));
          chk("abort end busy", 32'(busy), 32'(0));
          abort_phase = 0;
        end
        if (tx_start || (req_ack != '0)) match(K_GRANT);
        if (req_done != '0) match(K_DONE);
        if (timeout_err) begin
          match(K_TO);
          abort_phase = 1;
        end
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic to_cycle(input int t);
    while (cyc < t) wait_cyc(1);
  endtask

  // One SCLK period: 3 clk low, 3 clk high; the fall is driven at entry
  task automatic fall_pulse();
    sclk = 1'b0;
    wait_cyc(3);
    sclk = 1'b1;
    wait_cyc(3);
  endtask

  task automatic send_falls(input int n);
    repeat (n) fall_pulse();
  endtask

  // Full word from the current cycle; done lands 5 cycles after the last fall
  task automatic xfer(input int idx, input bit has_next, input int nidx);
    int done_at;
    done_at = cyc + 6 * (EDGES - 1) + 5;
    push(K_DONE, idx, done_at);
    if (has_next) push(K_GRANT, nidx, done_at + 1);
    send_falls(EDGES);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, " tx_reset"}, 32'(tx_reset), 32'(1));
    chk({tag, " busy"}, 32'(busy), 32'(0));
    chk({tag, " tx_start"}, 32'(tx_start), 32'(0));
    chk({tag, " req_ack"}, 32'(req_ack), 32'(0));
    chk({tag, " req_done"}, 32'(req_done), 32'(0));
    chk({tag, " timeout_err"}, 32'(timeout_err), 32'(0));
    chk({tag, " owner"}, 32'(owner), 32'(0));
    chk({tag, " tx_data"}, 32'(tx_data), 32'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int p;
    int f;
    wd[0] = 16'h0F0F;
    wd[1] = 16'h1234;
    wd[2] = 16'hA5C3;
    wd[3] = 16'hBEEF;
    req_data = {wd[3], wd[2], wd[1], wd[0]};
    reset_n = 1'b0;
    req     = '0;
    sclk    = 1'b1;

    // Reset values
    wait_cyc(2);
    check_reset_outputs("reset");
    reset_n = 1'b1;
    wait_cyc(2);
    chk("post reset tx_reset", 32'(tx_reset), 32'(0));

    // Single word from requester 2
    p = cyc;
    req = 4'b0100;
    push(K_GRANT, 2, p + 1);
    wait_cyc(1);
    req = '0;
    xfer(2, 1'b0, 0);
    chk("single idle busy", 32'(busy), 32'(0));

    // Wrap: ptr is 3, requests 0 and 2 -> 0 then 2
    p = cyc;
    req = 4'b0101;
    push(K_GRANT, 0, p + 1);
    wait_cyc(1);
    req[0] = 1'b0;
    xfer(0, 1'b1, 2);
    req[2] = 1'b0;
    xfer(2, 1'b0, 0);

    // SCLK noise while idle must not start anything or pre-count edges
    repeat (4) begin
      fall_pulse();
      chk("idle noise busy", 32'(busy), 32'(0));
    end
    p = cyc;
    req = 4'b0010;
    push(K_GRANT, 1, p + 1);
    wait_cyc(1);
    req = '0;
    send_falls(EDGES - 1);
    wait_cyc(10);
    chk("16 falls still busy", 32'(busy), 32'(1));
    push(K_DONE, 1, cyc + 5);
    fall_pulse();

    // Timeout: 5 falls then the master stops
    p = cyc;
    req = 4'b1000;
    push(K_GRANT, 3, p + 1);
    wait_cyc(1);
    req = '0;
    f = cyc;
    push(K_TO, 3, f + 24 + 3 + TOC);
    send_falls(5);
    to_cycle(f + 24 + 3 + TOC + 4);
    chk("after abort busy", 32'(busy), 32'(0));
    chk("after abort tx_reset", 32'(tx_reset), 32'(0));

    // Round robin with 1011 held from ptr 0: 0,1,3,0
    p = cyc;
    req = 4'b1011;
    push(K_GRANT, 0, p + 1);
    wait_cyc(1);
    xfer(0, 1'b1, 1);
    xfer(1, 1'b1, 3);
    xfer(3, 1'b1, 0);
    req = '0;
    xfer(0, 1'b0, 0);

    // Reset at the 8th fall of a word
    p = cyc;
    req = 4'b0010;
    push(K_GRANT, 1, p + 1);
    wait_cyc(1);
    req = '0;
    send_falls(7);
    sclk = 1'b0;
    reset_n = 1'b0;
    #2;
    check_reset_outputs("mid-word reset");
    wait_cyc(2);
    sclk = 1'b1;
    wait_cyc(2);
    reset_n = 1'b1;
    wait_cyc(2);
    p = cyc;
    req = 4'b0100;
    push(K_GRANT, 2, p + 1);
    wait_cyc(1);
    req = '0;
    xfer(2, 1'b0, 0);
    chk("post reset word idle", 32'(busy), 32'(0));

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) wait_cyc(1);
    chk("expectations drained", 32'(exp_q.size()), 32'(0));
    wait_cyc(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_tx_arbiter.md
# spi_tx_arbiter

Round-robin arbiter and sequencer for the 16-bit SPI slave transmitter in the SPI pattern generator. Up to NUM_REQ local requesters post words. The block grants one requester at a time and hands its word to the transmitter with a one-cycle start pulse. It tracks the master's SCLK falling edges to know when the word has left the MISO pin. If the master stalls mid-word, it resets the transmitter and reports a timeout.

## Interface
- NUM_REQ, 4: number of requesters, 2..8.
- WORD_W, 16: word width; must equal the transmitter width.
- EDGES_PER_WORD, 17: SCLK falling edges per word. The transmitter needs 1 load edge plus 16 shift edges.
- GUARD_CYCLES, 2: clk cycles after the last edge before the word counts as done. Covers the transmitter's FINISH→WAIT return.
- TIMEOUT_CYCLES, 4096: maximum clk cycles between consecutive SCLK falling edges in SHIFT.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset, asynchronous assert, active-low.
- req  in  NUM_REQ  request level per requester. Held until acked.
- req_data  in  NUM_REQ*WORD_W  word i is at [i*WORD_W +: WORD_W]. Must be stable while req[i]=1.
- req_ack  out  NUM_REQ  one-cycle pulse when the word is captured.
- req_done  out  NUM_REQ  one-cycle pulse when the word is fully shifted out.
- sclk  in  1  raw SPI clock from the master, asynchronous.
- tx_start  out  1  one-cycle start pulse to the transmitter.
- tx_data  out  WORD_W  word to the transmitter, registered.
- tx_reset  out  1  active-high reset to the transmitter.
- busy  out  1  high in any state other than IDLE.
- owner  out  clog2(NUM_REQ)  index of the current or last granted requester.
- timeout_err  out  1  one-cycle pulse on abort.

## Operation
- SCLK path:
  - sclk passes through a 2-flop synchronizer, then a falling-edge detector.
  - This produces `fall`, a one-cycle pulse.
- States: IDLE, LOAD, SHIFT, GUARD, ABORT.
- IDLE:
  - If any req bit is set, pick the first set bit scanning upward from ptr, wrapping modulo NUM_REQ.
  - Register tx_data ← that word and owner ← that index, then go to LOAD.
  - With no request, stay in IDLE.
- LOAD:
  - tx_start=1 and req_ack[owner]=1 for exactly this cycle.
  - ptr ← (owner+1) mod NUM_REQ.
  - Clear edge_cnt and to_cnt, then go to SHIFT.
- SHIFT:
  - On each `fall`: edge_cnt+1 and to_cnt←0. Otherwise to_cnt+1, saturating.
  - When edge_cnt reaches EDGES_PER_WORD, go to GUARD.
  - If to_cnt reaches TIMEOUT_CYCLES-1 with no `fall`, go to ABORT.
- GUARD:
  - Count GUARD_CYCLES cycles, then go to IDLE.
  - req_done[owner] pulses in the first IDLE cycle.
  - `fall` in GUARD is ignored.
- ABORT:
  - tx_reset=1 for 2 cycles, and timeout_err pulses in the first of them.
  - No req_done is issued; the word is dropped.
  - Then go to IDLE. ptr has already advanced, so the word is not retried automatically.
- edge_cnt width is clog2(EDGES_PER_WORD+1). to_cnt width is clog2(TIMEOUT_CYCLES).
- Any `fall` in IDLE or LOAD is ignored; the counters stay cleared.
- Request bits that drop before being granted are simply skipped.
- req_data of non-granted requesters is never sampled.

## Timing
- Reset values:
  - state=IDLE, ptr=0, owner=0, tx_data=0, edge_cnt=0, to_cnt=0, synchronizer flops=1 (SCLK idles high).
  - Outputs: req_ack=0, req_done=0, tx_start=0, busy=0, timeout_err=0.
- tx_reset = ~reset_n OR abort. It is asserted while reset_n is low.
- Grant latency: req sampled high in IDLE at cycle N → tx_start and req_ack in cycle N+1 → SHIFT from N+2.
- tx_data is valid from cycle N+1 and held until the next grant.
- Edge latency: a raw sclk fall produces `fall` 2–3 clk cycles later. SCLK high and low phases must each last at least 3 clk cycles.
- Done: GUARD lasts exactly GUARD_CYCLES cycles, then req_done is asserted in the first IDLE cycle.
- Back-to-back: a pending request is granted in that same first IDLE cycle, so the next tx_start comes 1 cycle later.
- Asserting reset_n mid-word returns to IDLE immediately. No done or ack pulse is produced.

## Test plan
- Single word: req[2]=1 with data 0xA5C3, master drives 17 falls.
  - Required: ack[2] and tx_start coincide with tx_data=0xA5C3.
  - done[2] pulses 2 cycles after GUARD entry.
- Round robin: req=4'b1011 held, ptr=0.
  - Required: grant order 0,1,3,0.
  - Each grant is 1 cycle after the previous done.
- Wrap: ptr=3, req=4'b0101.
  - Required: grant 0, then 2.
- Timeout: grant, then SCLK stops after 5 falls.
  - Required: after TIMEOUT_CYCLES, timeout_err pulses, tx_reset is high for 2 cycles, there is no done, and the block is back in IDLE.
- Idle noise: SCLK toggles in IDLE.
  - Required: no state change, edge_cnt=0.
  - On a later grant, exactly 17 falls are still required.
- Reset mid-SHIFT: reset_n low at the 8th fall.
  - Required: all outputs at reset values, tx_reset=1 during reset.
  - After release, a new request completes normally.
